// File: rtl/parallel_pe.sv
// Multi-lane signed multiply-accumulate PE: LANES products per beat, adder tree,
// vector accumulation under start/last control, saturating or truncating result.
module parallel_pe #(
  parameter int LANES  = 32,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 48,
  parameter int OUT_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*DATA_W-1:0] neuron,
  input  logic [LANES*DATA_W-1:0] weight,
  input  logic [1:0]              ctl,
  input  logic                    vld_i,
  input  logic                    sat_en,
  output logic [OUT_W-1:0]        result,
  output logic                    ovf,
  output logic [CNT_W-1:0]        cnt,
  output logic                    vld_o
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);

  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Handshake: a beat is accepted on every rising edge where vld_i=1; there is
  // no ready, so the producer may issue a beat every cycle. vld_o is a one-cycle
  // pulse marking result/ovf/cnt as a fresh vector result.

  // P1 stage
  logic signed [PROD_W-1:0] prod_d [LANES];
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic                     p1_vld_q;
  logic [1:0]               p1_ctl_q;
  logic                     p1_sat_q;

  // P2 stage
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [SUM_W-1:0]  sum_q;
  logic                     p2_vld_q;
  logic [1:0]               p2_ctl_q;
  logic                     p2_sat_q;

  // ACC stage
  logic signed [ACC_W-1:0]  sum_ext;
  logic signed [ACC_W-1:0]  acc_d, acc_q;
  logic [CNT_W-1:0]         cnt_r_d, cnt_r_q;
  logic                     out_ld_d, out_ld_q;
  logic                     out_sat_d, out_sat_q;

  // OUT stage
  logic [OUT_W-1:0]         result_d, result_q;
  logic                     ovf_d, ovf_q;
  logic [CNT_W-1:0]         cnt_d, cnt_q;
  logic                     vld_o_q;
  logic                     acc_hi, acc_lo;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = PROD_W'($signed(neuron[i*DATA_W +: DATA_W])) *
                  PROD_W'($signed(weight[i*DATA_W +: DATA_W]));
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + SUM_W'(prod_q[i]);
    end
  end

  assign sum_ext = ACC_W'(sum_q);

  // A start beat overwrites any open partial sum, which silently drops that vector.
  always_comb begin
    acc_d     = acc_q;
    cnt_r_d   = cnt_r_q;
    out_ld_d  = 1'b0;
    out_sat_d = out_sat_q;
    if (p2_vld_q) begin
      if (p2_ctl_q[0]) begin
        acc_d   = sum_ext;
        cnt_r_d = CNT_W'(1);
      end else begin
        acc_d   = acc_q + sum_ext;
        cnt_r_d = cnt_r_q + CNT_W'(1);
      end
      out_ld_d  = p2_ctl_q[1];
      out_sat_d = p2_sat_q;
    end
  end

  assign acc_hi = (acc_q > OUT_MAX);
  assign acc_lo = (acc_q < OUT_MIN);

  always_comb begin
    result_d = result_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    if (out_ld_q) begin
      ovf_d = acc_hi | acc_lo;
      cnt_d = cnt_r_q;
      if (out_sat_q && acc_hi)      result_d = OUT_MAX[OUT_W-1:0];
      else if (out_sat_q && acc_lo) result_d = OUT_MIN[OUT_W-1:0];
      else                          result_d = acc_q[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q    <= '{default: '0};
      p1_vld_q  <= 1'b0;
      p1_ctl_q  <= 2'b00;
      p1_sat_q  <= 1'b0;
      sum_q     <= '0;
      p2_vld_q  <= 1'b0;
      p2_ctl_q  <= 2'b00;
      p2_sat_q  <= 1'b0;
      acc_q     <= '0;
      cnt_r_q   <= '0;
      out_ld_q  <= 1'b0;
      out_sat_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      vld_o_q   <= 1'b0;
    end else begin
      p1_vld_q <= vld_i;
      if (vld_i) begin
        prod_q   <= prod_d;
        p1_ctl_q <= ctl;
        p1_sat_q <= sat_en;
      end
      p2_vld_q <= p1_vld_q;
      if (p1_vld_q) begin
        sum_q    <= sum_d;
        p2_ctl_q <= p1_ctl_q;
        p2_sat_q <= p1_sat_q;
      end
      acc_q     <= acc_d;
      cnt_r_q   <= cnt_r_d;
      out_ld_q  <= out_ld_d;
      out_sat_q <= out_sat_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      vld_o_q   <= out_ld_q;
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;
  assign cnt    = cnt_q;
  assign vld_o  = vld_o_q;

endmodule

// File: tb/tb_parallel_pe.sv
// Directed plus random bench for parallel_pe with a reference model and a
// scoreboard of expected {result, ovf, cnt} and arrival cycle.
module tb_parallel_pe;

  localparam int LANES  = 32;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 48;
  localparam int OUT_W  = 32;
  localparam int CNT_W  = 16;
  localparam int LW     = LANES * DATA_W;
  localparam int EW     = OUT_W + 1 + CNT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [LW-1:0]     neuron = '0;
  logic [LW-1:0]     weight = '0;
  logic [1:0]        ctl = 2'b00;
  logic              vld_i = 1'b0;
  logic              sat_en = 1'b0;
  logic [OUT_W-1:0]  result;
  logic              ovf;
  logic [CNT_W-1:0]  cnt;
  logic              vld_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [EW-1:0] hold_exp = '0;

  longint acc_m = 0;
  int     cnt_m = 0;

  parallel_pe #(
    .LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .neuron(neuron), .weight(weight), .ctl(ctl),
    .vld_i(vld_i), .sat_en(sat_en), .result(result), .ovf(ovf), .cnt(cnt),
    .vld_o(vld_o)
  );

  // clock/reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rep(input logic [DATA_W-1:0] x);
    return {LANES{x}};
  endfunction

  // driver: updates the reference model and drives one beat
  task automatic beat(input logic [LW-1:0] n, input logic [LW-1:0] w,
                      input logic [1:0] c, input logic s);
    longint sum = 0;
    longint lim_hi = 64'sd2147483647;
    longint lim_lo = -64'sd2147483648;
    logic [OUT_W-1:0] r;
    logic o;
    logic [63:0] a64;
    for (int i = 0; i < LANES; i++) begin
      sum += longint'($signed(n[i*DATA_W +: DATA_W])) * longint'($signed(w[i*DATA_W +: DATA_W]));
    end
    if (c[0]) begin
      acc_m = sum;
      cnt_m = 1;
    end else begin
      acc_m = acc_m + sum;
      cnt_m = (cnt_m + 1) & 32'hFFFF;
    end
    acc_m = (acc_m <<< (64 - ACC_W)) >>> (64 - ACC_W);
    @(posedge clk);
    #1;
    neuron = n; weight = w; ctl = c; sat_en = s; vld_i = 1'b1;
    if (c[1]) begin
      o = (acc_m > lim_hi) || (acc_m < lim_lo);
      a64 = acc_m;
      if (s && acc_m > lim_hi)      r = 32'h7FFF_FFFF;
      else if (s && acc_m < lim_lo) r = 32'h8000_0000;
      else                          r = a64[OUT_W-1:0];
      exp_q.push_back({r, o, cnt_m[CNT_W-1:0]});
      exp_cyc_q.push_back(cyc + 4);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      vld_i = 1'b0;
      ctl = 2'b00;
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (vld_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_vld_o", 64'(cyc), 64'(0));
        end else begin
          hold_exp = exp_q.pop_front();
          chk("out_data", 64'({result, ovf, cnt}), 64'(hold_exp));
          chk("out_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
        end
      end else begin
        chk("out_hold", 64'({result, ovf, cnt}), 64'(hold_exp));
      end
    end
  end

  initial begin
    logic [LW-1:0] lane_idx;
    logic [LW-1:0] rn, rw;
    logic [1:0]    rc;

    for (int i = 0; i < LANES; i++) lane_idx[i*DATA_W +: DATA_W] = DATA_W'(i);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_cnt", 64'(cnt), 64'(0));
    chk("rst_vld_o", 64'(vld_o), 64'(0));
    mon_en = 1'b1;

    // single beat: 32 x (1*2) = 64
    beat(rep(16'd1), rep(16'd2), 2'b11, 1'b0);
    idle(6);

    // back-to-back vectors A (1984, cnt 4) and B (-64, cnt 2)
    beat(lane_idx, rep(16'd1), 2'b01, 1'b0);
    beat(lane_idx, rep(16'd1), 2'b00, 1'b0);
    beat(lane_idx, rep(16'd1), 2'b00, 1'b0);
    beat(lane_idx, rep(16'd1), 2'b10, 1'b0);
    beat(rep(16'hFFFF), rep(16'd1), 2'b01, 1'b0);
    beat(rep(16'hFFFF), rep(16'd1), 2'b10, 1'b0);
    idle(6);

    // vector A with 3 bubbles between beats
    beat(lane_idx, rep(16'd1), 2'b01, 1'b0);
    idle(3);
    beat(lane_idx, rep(16'd1), 2'b00, 1'b0);
    idle(3);
    beat(lane_idx, rep(16'd1), 2'b00, 1'b0);
    idle(3);
    beat(lane_idx, rep(16'd1), 2'b10, 1'b0);
    idle(6);

    // overflow: saturate, truncate, most-negative squared
    beat(rep(16'h7FFF), rep(16'h7FFF), 2'b11, 1'b1);
    beat(rep(16'h7FFF), rep(16'h7FFF), 2'b11, 1'b0);
    beat(rep(16'h8000), rep(16'h8000), 2'b11, 1'b1);
    idle(6);

    // restart discards the open vector: 64 + 32 = 96, cnt 2
    beat(rep(16'd1), rep(16'd1), 2'b01, 1'b0);
    beat(rep(16'd1), rep(16'd1), 2'b00, 1'b0);
    beat(rep(16'd1), rep(16'd1), 2'b00, 1'b0);
    beat(rep(16'd2), rep(16'd1), 2'b01, 1'b0);
    beat(rep(16'd1), rep(16'd1), 2'b10, 1'b0);
    idle(6);

    // reset in the middle of an open vector
    beat(rep(16'd3), rep(16'd1), 2'b01, 1'b0);
    beat(rep(16'd3), rep(16'd1), 2'b00, 1'b0);
    @(posedge clk);
    #1;
    vld_i = 1'b0;
    rst = 1'b1;
    acc_m = 0;
    cnt_m = 0;
    hold_exp = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_result", 64'(result), 64'(0));
    chk("midrst_cnt", 64'(cnt), 64'(0));
    chk("midrst_ovf", 64'(ovf), 64'(0));
    idle(6);
    beat(rep(16'd1), rep(16'd1), 2'b11, 1'b0);
    idle(6);

    // random vectors with random gaps and control
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < LANES; i++) begin
        rn[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 65535));
        rw[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 65535));
      end
      rc = 2'($urandom_range(0, 3));
      beat(rn, rw, rc, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    beat(lane_idx, lane_idx, 2'b10, 1'b1);
    idle(1);

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
